uart_rs232_rx: RTL

UART_RS232_RX -- requirements
Module: uart_rs232_rx

---
 rtl/uart_rs232_rx_pkg.sv | 28 ++
 rtl/uart_rs232_rx_sync2.sv | 23 ++
 rtl/uart_rs232_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_rs232_rx_pkg.sv
// Shared UART definitions: receiver state encoding, framing limits and
// small helpers used by the RS-232 transmitter and receiver.
package uart_rs232_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int          OVERSAMPLE_DEF = 16;
    localparam logic [3:0]  NBITS_MIN      = 4'd5;
    localparam logic [3:0]  NBITS_MAX      = 4'd8;

    // Out-of-range frame lengths fall back to a full byte.
    function automatic logic [3:0] nbits_sanitize(input logic [3:0] n);
        return (n >= NBITS_MIN && n <= NBITS_MAX) ? n : NBITS_MAX;
    endfunction

    // Bits enter at the MSB end of the shift register, so an n-bit frame
    // sits in the top n bits; shifting down right-justifies and zero-fills.
    function automatic logic [7:0] justify(input logic [7:0] sr, input logic [3:0] n);
        return sr >> (NBITS_MAX - n);
    endfunction

endpackage

// File: rtl/uart_rs232_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rs232_rx.sv
// RS-232 receiver: oversampled start detection, mid-bit data sampling,
// stop-bit check with framing-error flag and break-state hold-off.
module uart_rs232_rx
    import uart_rs232_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       RxEn,
    input  logic       Rx,
    input  logic       Tick,
    input  logic [3:0] NBits,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr
);

    localparam int             CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic             rx_s;
    rx_state_t        state_q,    state_nxt;
    logic [CNT_W-1:0] cnt_q,      cnt_nxt;
    logic [3:0]       bit_cnt_q,  bit_cnt_nxt;
    logic [3:0]       nbits_q,    nbits_nxt;
    logic [7:0]       shift_q,    shift_nxt;
    logic [7:0]       rx_data_q,  rx_data_nxt;
    logic             frame_err_q, frame_err_nxt;
    logic             rx_done_q,  rx_done_nxt;
    logic [3:0]       bit_cnt_inc;

    uart_sync2 u_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Rx),
        .q     (rx_s)
    );

    assign bit_cnt_inc = bit_cnt_q + 4'd1;

    // Next-state and datapath update; everything advances only on Tick,
    // except the enable abort and the single-cycle RxDone pulse.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        bit_cnt_nxt   = bit_cnt_q;
        nbits_nxt     = nbits_q;
        shift_nxt     = shift_q;
        rx_data_nxt   = rx_data_q;
        frame_err_nxt = frame_err_q;
        rx_done_nxt   = 1'b0;

        if (!RxEn) begin
            state_nxt = ST_IDLE;
        end else if (Tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nxt = ST_START;
                        cnt_nxt   = '0;
                        nbits_nxt = nbits_sanitize(NBits);
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            state_nxt   = ST_DATA;
                            cnt_nxt     = '0;
                            bit_cnt_nxt = 4'd0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_nxt   = {rx_s, shift_q[7:1]};
                        cnt_nxt     = '0;
                        bit_cnt_nxt = bit_cnt_inc;
                        if (bit_cnt_inc == nbits_q) begin
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        rx_data_nxt   = justify(shift_q, nbits_q);
                        frame_err_nxt = ~rx_s;
                        rx_done_nxt   = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold off start detection until the line is released.
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 4'd0;
            nbits_q     <= NBITS_MAX;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            bit_cnt_q   <= bit_cnt_nxt;
            nbits_q     <= nbits_nxt;
            shift_q     <= shift_nxt;
            rx_data_q   <= rx_data_nxt;
            frame_err_q <= frame_err_nxt;
            rx_done_q   <= rx_done_nxt;
        end
    end

    assign RxData   = rx_data_q;
    assign RxDone   = rx_done_q;
    assign FrameErr = frame_err_q;

endmodule
